// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit with a doubleword memory bus
module lsu #(
    parameter int REG_WIDTH = 64,
    parameter int ADDR_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [REG_WIDTH-1:0] alu_result,
    input  logic [REG_WIDTH-1:0] store_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_data,
    output logic                 out_misalign,
    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic                 bus_req_we,
    output logic [ADDR_W-1:0]    bus_req_addr,
    output logic [63:0]          bus_req_wdata,
    output logic [7:0]           bus_req_wmask,
    input  logic                 bus_rsp_valid,
    input  logic [63:0]          bus_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_store;
    logic [2:0]             r_funct3;
    logic [1:0]             r_size;
    logic [ADDR_W-1:0]      r_addr;
    logic [REG_WIDTH-1:0]   r_sdata;
    logic                   r_misalign;
    logic [REG_WIDTH-1:0]   r_out_data;

    logic                   w_hs;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_is_mem;
    logic [1:0]             w_size_in;
    logic                   w_misalign_in;
    logic [ADDR_W-1:0]      w_addr_in;
    logic [2:0]             w_off;
    logic [63:0]            w_lane;
    logic [63:0]            w_load_ext;
    logic [63:0]            w_sdata64;
    logic [7:0]             w_mask_base;

    assign w_hs       = in_valid && (r_state == IDLE);
    // Both flags set is resolved as a load.
    assign w_is_load  = mem_read;
    assign w_is_store = mem_write && !mem_read;
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_addr_in  = ADDR_W'(alu_result);

    // Access size as log2(bytes); stores with funct3=1xx are byte stores.
    always_comb begin
        w_size_in = funct3[1:0];
        if (w_is_store && funct3[2]) begin
            w_size_in = 2'd0;
        end
    end

    // Natural-alignment check on the incoming address.
    always_comb begin
        w_misalign_in = 1'b0;
        case (w_size_in)
            2'd1:    w_misalign_in = w_addr_in[0];
            2'd2:    w_misalign_in = (w_addr_in[1:0] != 2'b00);
            2'd3:    w_misalign_in = (w_addr_in[2:0] != 3'b000);
            default: w_misalign_in = 1'b0;
        endcase
        w_misalign_in = w_misalign_in && w_is_mem;
    end

    assign w_off     = r_addr[2:0];
    assign w_lane    = bus_rsp_rdata >> {w_off, 3'b000};
    assign w_sdata64 = 64'(r_sdata);

    // Load lane extraction: signed B/H/W, unsigned BU/HU/WU, full D.
    always_comb begin
        w_load_ext = w_lane;
        case (r_funct3)
            3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_load_ext = {56'd0, w_lane[7:0]};
            3'b101:  w_load_ext = {48'd0, w_lane[15:0]};
            3'b110:  w_load_ext = {32'd0, w_lane[31:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    // Byte strobes before lane shifting, by access size.
    always_comb begin
        w_mask_base = 8'h01;
        case (r_size)
            2'd0:    w_mask_base = 8'h01;
            2'd1:    w_mask_base = 8'h03;
            2'd2:    w_mask_base = 8'h0F;
            default: w_mask_base = 8'hFF;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (w_is_mem && !w_misalign_in) ? REQ : DONE;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus_rsp_valid) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operation capture and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store    <= 1'b0;
            r_funct3   <= 3'd0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_misalign <= 1'b0;
            r_out_data <= '0;
        end else if (w_hs) begin
            r_store    <= w_is_store;
            r_funct3   <= funct3;
            r_size     <= w_size_in;
            r_addr     <= w_addr_in;
            r_sdata    <= store_data;
            r_misalign <= w_misalign_in;
            r_out_data <= w_is_mem ? '0 : alu_result;
        end else if ((r_state == WAIT) && bus_rsp_valid) begin
            r_out_data <= r_store ? '0 : REG_WIDTH'(w_load_ext);
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = (r_state == DONE);
    assign out_data      = r_out_data;
    assign out_misalign  = (r_state == DONE) && r_misalign;
    assign bus_req_valid = (r_state == REQ);
    assign bus_req_we    = (r_state == REQ) && r_store;
    assign bus_req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign bus_req_wdata = w_sdata64 << {w_off, 3'b000};
    assign bus_req_wmask = ((r_state == REQ) && r_store) ? (w_mask_base << w_off) : 8'h00;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against a behavioural model
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_misalign;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_rsp_valid;
    logic [63:0] bus_rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    lsu #(.REG_WIDTH(64), .ADDR_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_misalign  (out_misalign),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wmask (bus_req_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata)
    );

    always @(posedge clk) begin
        if (rst_n && bus_req_valid && bus_req_ready) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour expressed with byte sizes and plain arithmetic.
    task automatic model_op(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] sdata,
                            input logic [63:0] rdata,
                            output bit is_mem, output bit mis, output bit we,
                            output logic [63:0] data, output logic [63:0] wdata,
                            output logic [7:0] wmask);
        int size;
        int o;
        bit sgn;
        logic [63:0] v;
        logic [63:0] lim;
        o      = int'(addr % 8);
        is_mem = rd || wr;
        we     = wr && !rd;
        if (we && f3 >= 4) size = 1;
        else begin
            case (f3 % 4)
                0: size = 1;
                1: size = 2;
                2: size = 4;
                default: size = 8;
            endcase
        end
        sgn   = !we && (f3 < 3);
        mis   = is_mem && ((addr % size) != 0);
        wdata = sdata << (8 * o);
        wmask = 8'((((1 << size) - 1)) << o);
        if (!is_mem) data = addr;
        else if (mis || we) data = 64'd0;
        else begin
            v = rdata >> (8 * o);
            if (size < 8) begin
                lim = (64'd1 << (8 * size));
                v = v % lim;
                if (sgn && (v >= lim / 2)) v = v + ~(lim - 64'd1);
            end
            data = v;
        end
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [63:0] rdata, input int req_stall,
                         input int rsp_delay, input int out_stall);
        bit is_mem, mis, we;
        logic [63:0] data, wdata;
        logic [7:0] wmask;
        int a0;
        model_op(rd, wr, f3, addr, sdata, rdata, is_mem, mis, we, data, wdata, wmask);
        a0 = acc_cnt;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; store_data = sdata;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = $urandom; mem_write = $urandom;
        alu_result = {$urandom, $urandom}; store_data = {$urandom, $urandom};
        if (!is_mem || mis) begin
            chk("lat1_valid", 64'(out_valid), 64'd1);
            chk("no_req", 64'(bus_req_valid), 64'd0);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                chk("req_valid", 64'(bus_req_valid), 64'd1);
                chk("req_addr", bus_req_addr, addr & ~64'h7);
                chk("req_we", 64'(bus_req_we), 64'(we));
                if (we) begin
                    chk("req_wdata", bus_req_wdata, wdata);
                    chk("req_wmask", 64'(bus_req_wmask), 64'(wmask));
                end
                chk("busy_req", 64'(in_ready), 64'd0);
                bus_rsp_valid = $urandom;
                bus_rsp_rdata = {$urandom, $urandom};
                if (i == req_stall) bus_req_ready = 1'b1;
                @(posedge clk); #1;
                bus_req_ready = 1'b0;
                bus_rsp_valid = 1'b0;
            end
            for (int i = 0; i <= rsp_delay; i++) begin
                chk("wait_noout", 64'(out_valid), 64'd0);
                chk("wait_noreq", 64'(bus_req_valid), 64'd0);
                bus_rsp_rdata = {$urandom, $urandom};
                if (i == rsp_delay) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_rdata = rdata;
                end
                @(posedge clk); #1;
                bus_rsp_valid = 1'b0;
            end
        end
        for (int i = 0; i <= out_stall; i++) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_data", out_data, data);
            chk("out_misalign", 64'(out_misalign), 64'(mis));
            chk("busy_done", 64'(in_ready), 64'd0);
            if (i == out_stall) out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        chk("back_idle", 64'(out_valid), 64'd0);
        chk("acc_count", 64'(acc_cnt - a0), (is_mem && !mis) ? 64'd1 : 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_misalign"}, 64'(out_misalign), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_req_valid"}, 64'(bus_req_valid), 64'd0);
        chk({tag, "_req_we"}, 64'(bus_req_we), 64'd0);
        chk({tag, "_wmask"}, 64'(bus_req_wmask), 64'd0);
    endtask

    initial begin
        int a0;
        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; alu_result = '0; store_data = '0; out_ready = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;

        do_op(0, 0, 3'd0, 64'h1234, 64'd0, 64'd0, 0, 0, 0);
        do_op(1, 0, 3'b000, 64'h1003, 64'd0, 64'h00000000_80FF0000, 0, 0, 0);
        do_op(1, 0, 3'b100, 64'h1003, 64'd0, 64'h00000000_80FF0000, 0, 0, 0);
        do_op(0, 1, 3'b001, 64'h2006, 64'hABCD, 64'd0, 0, 0, 0);
        do_op(1, 0, 3'b010, 64'h3002, 64'd0, 64'd0, 0, 0, 0);
        do_op(1, 0, 3'b011, 64'h4008, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 2, 3);
        do_op(1, 1, 3'b101, 64'h500E, 64'hFFFF, 64'h8001_0000_0000_0000, 1, 0, 0);
        do_op(0, 1, 3'b110, 64'h6005, 64'h1122_3344_5566_7788, 64'd0, 0, 1, 0);
        do_op(0, 1, 3'b011, 64'h7000, 64'h1122_3344_5566_7788, 64'd0, 2, 0, 1);

        // Reset while waiting for a response, then a stale response.
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
        alu_result = 64'h8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        chk_reset_vals("late_rsp");

        // Reset while requesting: the request is dropped, not retried.
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000;
        alu_result = 64'h9001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_req_valid_before", 64'(bus_req_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_req");
        @(posedge clk); #1;
        rst_n = 1'b1;
        a0 = acc_cnt;
        bus_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_req_ready = 1'b0;
        chk("no_retry", 64'(acc_cnt - a0), 64'd0);

        for (int n = 0; n < 300; n++) begin
            bit rd, wr;
            logic [2:0] f3;
            logic [63:0] addr;
            int k;
            k  = $urandom_range(0, 3);
            rd = k[0];
            wr = k[1];
            f3 = 3'($urandom_range(0, 6));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) addr[2:0] = 3'd0;
            do_op(rd, wr, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
